// File: rtl/cache_tag_maint_arbiter.sv
// Tag-RAM port arbiter for the AHB3 cache: the invalidate-all sweep wins over the
// lookup/fill pipeline, which wins over single-line invalidates.
module cache_tag_maint_arbiter #(
   parameter int unsigned SZ_IDX        = 11,
   parameter int unsigned SZ_TAG        = 19,
   parameter bit          INIT_ON_RESET = 1'b1
) (
   input  logic              HCLK,
   input  logic              HRESETn,
   input  logic              lookup_req,
   input  logic              lookup_we,
   input  logic [SZ_IDX-1:0] lookup_idx,
   input  logic [SZ_TAG-1:0] lookup_tag,
   output logic              lookup_gnt,
   output logic              stall,
   input  logic              inv_req,
   input  logic [SZ_IDX-1:0] inv_idx,
   output logic              inv_ack,
   input  logic              maint_req,
   output logic              maint_busy,
   output logic              maint_done,
   output logic              tram_en,
   output logic              tram_we,
   output logic [SZ_IDX-1:0] tram_idx,
   output logic [SZ_TAG-1:0] tram_wtag,
   output logic              tram_wvalid
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SWEEP = 2'd1,
      DONE  = 2'd2
   } state_e;

   localparam logic [SZ_IDX-1:0] LAST_IDX = '1;

   state_e            state_q;
   logic [SZ_IDX-1:0] sweep_cnt_q;
   logic [SZ_IDX-1:0] sweep_cnt_d;
   logic              sweep_act;

   assign sweep_cnt_d = sweep_cnt_q + SZ_IDX'(1);

   // Sweep sequencer; maint_req while sweeping restarts from index 0.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         state_q     <= INIT_ON_RESET ? SWEEP : IDLE;
         sweep_cnt_q <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (maint_req) begin
                  state_q     <= SWEEP;
                  sweep_cnt_q <= '0;
               end
            end
            SWEEP: begin
               if (maint_req) begin
                  sweep_cnt_q <= '0;
               end else begin
                  sweep_cnt_q <= sweep_cnt_d;
                  if (sweep_cnt_q == LAST_IDX) state_q <= DONE;
               end
            end
            DONE: begin
               state_q     <= maint_req ? SWEEP : IDLE;
               sweep_cnt_q <= '0;
            end
            default: begin
               state_q     <= IDLE;
               sweep_cnt_q <= '0;
            end
         endcase
      end
   end

   // Grants are qualified by HRESETn so nothing reaches the RAM while reset is held.
   assign sweep_act  = HRESETn && (state_q == SWEEP);
   assign lookup_gnt = HRESETn && lookup_req && !sweep_act;
   assign stall      = HRESETn && lookup_req && !lookup_gnt;
   assign inv_ack    = HRESETn && inv_req && !lookup_req && !sweep_act;
   assign maint_busy = (state_q == SWEEP);
   assign maint_done = (state_q == DONE);

   // Tag-RAM port mux of the granted source.
   always_comb begin
      tram_en     = 1'b0;
      tram_we     = 1'b0;
      tram_idx    = '0;
      tram_wtag   = '0;
      tram_wvalid = 1'b0;
      if (sweep_act) begin
         tram_en  = 1'b1;
         tram_we  = 1'b1;
         tram_idx = sweep_cnt_q;
      end else if (lookup_gnt) begin
         tram_en     = 1'b1;
         tram_we     = lookup_we;
         tram_idx    = lookup_idx;
         tram_wtag   = lookup_tag;
         tram_wvalid = lookup_we;
      end else if (inv_ack) begin
         tram_en  = 1'b1;
         tram_we  = 1'b1;
         tram_idx = inv_idx;
      end
   end

endmodule

// File: tb/tb_cache_tag_maint_arbiter.sv
// Directed bench for cache_tag_maint_arbiter: expected output vectors are queued as
// stimulus is driven and compared against the DUT on the following falling edge.
module tb_cache_tag_maint_arbiter;

   logic        HCLK;
   logic        HRESETn;
   logic        lookup_req;
   logic        lookup_we;
   logic [10:0] lookup_idx;
   logic [18:0] lookup_tag;
   logic        lookup_gnt;
   logic        stall;
   logic        inv_req;
   logic [10:0] inv_idx;
   logic        inv_ack;
   logic        maint_req;
   logic        maint_busy;
   logic        maint_done;
   logic        tram_en;
   logic        tram_we;
   logic [10:0] tram_idx;
   logic [18:0] tram_wtag;
   logic        tram_wvalid;

   logic [37:0] obs;
   logic [37:0] exp_q[$];
   string       tag_q[$];
   int          n_chk;
   int          n_fail;

   cache_tag_maint_arbiter #(.SZ_IDX(11), .SZ_TAG(19), .INIT_ON_RESET(1'b1)) dut (
      .HCLK(HCLK), .HRESETn(HRESETn),
      .lookup_req(lookup_req), .lookup_we(lookup_we), .lookup_idx(lookup_idx),
      .lookup_tag(lookup_tag), .lookup_gnt(lookup_gnt), .stall(stall),
      .inv_req(inv_req), .inv_idx(inv_idx), .inv_ack(inv_ack),
      .maint_req(maint_req), .maint_busy(maint_busy), .maint_done(maint_done),
      .tram_en(tram_en), .tram_we(tram_we), .tram_idx(tram_idx),
      .tram_wtag(tram_wtag), .tram_wvalid(tram_wvalid)
   );

   assign obs = {lookup_gnt, stall, inv_ack, maint_busy, maint_done,
                 tram_en, tram_we, tram_wvalid, tram_idx, tram_wtag};

   initial HCLK = 1'b0;
   always #5 HCLK = ~HCLK;

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", n_chk, n_fail);
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge HCLK);
      #1;
   endtask

   // Order: gnt stall ack busy done en we wvalid idx wtag
   task automatic expect_out(input string t, input bit gnt, input bit stl, input bit ack,
                             input bit busy, input bit done, input bit en, input bit we,
                             input bit wv, input logic [10:0] idx, input logic [18:0] wtag);
      exp_q.push_back({gnt, stl, ack, busy, done, en, we, wv, idx, wtag});
      tag_q.push_back(t);
   endtask

   task automatic smp();
      logic [37:0] e;
      string       t;
      @(negedge HCLK);
      n_chk++;
      if (exp_q.size() == 0) begin
         n_fail++;
         $error("FAIL scoreboard_empty observed=%h expected=<none>", obs);
      end else begin
         e = exp_q.pop_front();
         t = tag_q.pop_front();
         assert (obs === e) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", t, obs, e);
         end
      end
   endtask

   task automatic pulse_maint_from_idle(input string t);
      tick();
      maint_req = 1'b1;
      expect_out(t, 0,0,0,0,0,0,0,0, 11'h0, 19'h0);
      smp();
      tick();
      maint_req = 1'b0;
   endtask

   initial begin
      n_chk      = 0;
      n_fail     = 0;
      HRESETn    = 1'b0;
      lookup_req = 1'b0;
      lookup_we  = 1'b0;
      lookup_idx = '0;
      lookup_tag = '0;
      inv_req    = 1'b0;
      inv_idx    = '0;
      maint_req  = 1'b0;

      // Reset values: busy reflects the pending init sweep, everything else quiet.
      expect_out("rst_0", 0,0,0,1,0,0,0,0, 11'h0, 19'h0);
      smp();
      tick();
      expect_out("rst_1", 0,0,0,1,0,0,0,0, 11'h0, 19'h0);
      smp();

      // Init sweep after release: indices 0..2047, done at cycle 2048, then idle.
      tick();
      HRESETn = 1'b1;
      for (int i = 0; i < 2048; i++) begin
         if (i > 0) tick();
         expect_out("init_sweep", 0,0,0,1,0,1,1,0, 11'(i), 19'h0);
         smp();
      end
      tick();
      expect_out("init_done", 0,0,0,0,1,0,0,0, 11'h0, 19'h0);
      smp();
      tick();
      expect_out("init_idle", 0,0,0,0,0,0,0,0, 11'h0, 19'h0);
      smp();

      // Lookup fill held across a sweep: stalled throughout, granted in DONE.
      pulse_maint_from_idle("stall_idle");
      lookup_req = 1'b1;
      lookup_we  = 1'b1;
      lookup_idx = 11'h456;
      lookup_tag = 19'h12345;
      for (int i = 0; i < 2048; i++) begin
         if (i > 0) tick();
         expect_out("stall_sweep", 0,1,0,1,0,1,1,0, 11'(i), 19'h0);
         smp();
      end
      tick();
      expect_out("stall_done_gnt", 1,0,0,0,1,1,1,1, 11'h456, 19'h12345);
      smp();
      tick();
      lookup_req = 1'b0;
      lookup_we  = 1'b0;
      lookup_tag = '0;
      expect_out("stall_idle_after", 0,0,0,0,0,0,0,0, 11'h0, 19'h0);
      smp();

      // Lookup beats a simultaneous invalidate; invalidate issues once lookup drops.
      tick();
      inv_req    = 1'b1;
      inv_idx    = 11'h123;
      lookup_req = 1'b1;
      lookup_idx = 11'h456;
      expect_out("prio_lookup_0", 1,0,0,0,0,1,0,0, 11'h456, 19'h0);
      smp();
      tick();
      expect_out("prio_lookup_1", 1,0,0,0,0,1,0,0, 11'h456, 19'h0);
      smp();
      tick();
      lookup_req = 1'b0;
      expect_out("prio_inv_ack", 0,0,1,0,0,1,1,0, 11'h123, 19'h0);
      smp();
      tick();
      inv_req = 1'b0;
      expect_out("prio_quiet", 0,0,0,0,0,0,0,0, 11'h0, 19'h0);
      smp();

      // Fill at the top index.
      tick();
      lookup_req = 1'b1;
      lookup_we  = 1'b1;
      lookup_idx = 11'h7FF;
      lookup_tag = 19'h5A5A5;
      expect_out("fill_7ff", 1,0,0,0,0,1,1,1, 11'h7FF, 19'h5A5A5);
      smp();
      tick();
      lookup_req = 1'b0;
      lookup_we  = 1'b0;
      lookup_tag = '0;
      lookup_idx = '0;

      // Restart at sweep_cnt=1000: next cycle index 0, one done 2048 cycles later.
      pulse_maint_from_idle("restart_idle");
      for (int i = 0; i <= 1000; i++) begin
         if (i > 0) tick();
         if (i == 1000) maint_req = 1'b1;
         expect_out("restart_pre", 0,0,0,1,0,1,1,0, 11'(i), 19'h0);
         smp();
      end
      for (int i = 0; i < 2048; i++) begin
         tick();
         maint_req = 1'b0;
         expect_out("restart_post", 0,0,0,1,0,1,1,0, 11'(i), 19'h0);
         smp();
      end
      tick();
      expect_out("restart_done", 0,0,0,0,1,0,0,0, 11'h0, 19'h0);
      smp();
      tick();
      expect_out("restart_single_done", 0,0,0,0,0,0,0,0, 11'h0, 19'h0);
      smp();

      // Reset at sweep_cnt=500 aborts the sweep; init sweep restarts at index 0.
      pulse_maint_from_idle("abort_idle");
      for (int i = 0; i < 500; i++) begin
         if (i > 0) tick();
         expect_out("abort_pre", 0,0,0,1,0,1,1,0, 11'(i), 19'h0);
         smp();
      end
      tick();
      HRESETn = 1'b0;
      for (int i = 0; i < 3; i++) begin
         if (i > 0) tick();
         expect_out("abort_in_reset", 0,0,0,1,0,0,0,0, 11'h0, 19'h0);
         smp();
      end
      tick();
      HRESETn = 1'b1;
      for (int i = 0; i < 2048; i++) begin
         if (i > 0) tick();
         expect_out("abort_resweep", 0,0,0,1,0,1,1,0, 11'(i), 19'h0);
         smp();
      end
      tick();
      expect_out("abort_done", 0,0,0,0,1,0,0,0, 11'h0, 19'h0);
      smp();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
